// File: rtl/aluv_pkg.sv
// Shared constants, FSM state type and opcode helper for the vector-ALU execution unit.
package aluv_pkg;

  localparam logic [3:0] ALUV_ADD = 4'b0100;
  localparam logic [3:0] ALUV_SUB = 4'b1101;
  localparam logic [3:0] ALUV_MUL = 4'b0101;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  function automatic logic is_supported(input logic [3:0] sel);
    return (sel == ALUV_ADD) || (sel == ALUV_SUB) || (sel == ALUV_MUL);
  endfunction

endpackage

// File: rtl/aluv_if.sv
// Operand/selector request channel and result channel between the issue stage and the ALU.
interface aluv_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int LANES         = 8,
  parameter int SELECTOR_SIZE = 4
);
  logic                                in_valid;
  logic                                in_ready;
  logic [SELECTOR_SIZE-1:0]            selector;
  logic [LANES-1:0][DATA_WIDTH-1:0]    operand1;
  logic [LANES-1:0][DATA_WIDTH-1:0]    operand2;
  logic                                out_valid;
  logic                                out_ready;
  logic [LANES-1:0][DATA_WIDTH-1:0]    out;
  logic                                err;

  modport master (
    output in_valid, selector, operand1, operand2, out_ready,
    input  in_ready, out_valid, out, err
  );

  modport slave (
    input  in_valid, selector, operand1, operand2, out_ready,
    output in_ready, out_valid, out, err
  );
endinterface

// File: rtl/aluv_lane.sv
// Combinational single-lane ADD/SUB/MUL; unsupported selectors yield zero and raise unsup.
module aluv_lane
  import aluv_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int SELECTOR_SIZE = 4
) (
  input  logic [DATA_WIDTH-1:0]    a,
  input  logic [DATA_WIDTH-1:0]    b,
  input  logic [SELECTOR_SIZE-1:0] sel,
  output logic [DATA_WIDTH-1:0]    res,
  output logic                     unsup
);

  always_comb begin
    res   = '0;
    unsup = !is_supported(sel);
    case (sel)
      ALUV_ADD: res = a + b;
      ALUV_SUB: res = a - b;
      ALUV_MUL: res = DATA_WIDTH'(a * b);
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/aluv_exec_unit.sv
// Sequential vector-ALU: latches one request, computes LANES_PER_CYCLE lanes per cycle,
// and holds the result until the consumer takes it.
//   state | meaning
//   IDLE  | waiting for a request, in_ready=1
//   EXEC  | computing one lane group per cycle
//   DONE  | result held, out_valid=1; may accept the next request on retire
module aluv_exec_unit
  import aluv_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int LANES           = 8,
  parameter int SELECTOR_SIZE   = 4,
  parameter int LANES_PER_CYCLE = 2
) (
  input logic  clk,
  input logic  rst_n,
  aluv_if.slave bus
);

  localparam int NGROUPS = LANES / LANES_PER_CYCLE;
  localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  generate
    if (LANES % LANES_PER_CYCLE != 0) begin : g_bad_lpc
      $error("aluv_exec_unit: LANES must be divisible by LANES_PER_CYCLE");
    end
  endgenerate

  // Same bit layout as the flat lane vector, viewed as lane groups.
  typedef logic [NGROUPS-1:0][LANES_PER_CYCLE-1:0][DATA_WIDTH-1:0] grp_vec_t;

  state_t                                    state, state_nxt;
  logic [CNT_W-1:0]                          cnt;
  logic [SELECTOR_SIZE-1:0]                  sel_q;
  grp_vec_t                                  a_q, b_q, out_q;
  logic                                      out_valid_q, err_q;
  logic                                      accept, last_grp;
  logic [LANES_PER_CYCLE-1:0][DATA_WIDTH-1:0] res;
  logic [LANES_PER_CYCLE-1:0]                unsup;

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_grp      = (cnt == CNT_W'(NGROUPS - 1));
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;

  for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
    aluv_lane #(
      .DATA_WIDTH    (DATA_WIDTH),
      .SELECTOR_SIZE (SELECTOR_SIZE)
    ) u_lane (
      .a     (a_q[cnt][g]),
      .b     (b_q[cnt][g]),
      .sel   (sel_q),
      .res   (res[g]),
      .unsup (unsup[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: if (last_grp) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      sel_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept) begin
      sel_q       <= bus.selector;
      a_q         <= bus.operand1;
      b_q         <= bus.operand2;
      out_q       <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (state == EXEC) begin
      out_q[cnt] <= res;
      if (last_grp) begin
        cnt         <= '0;
        out_valid_q <= 1'b1;
        err_q       <= |unsup;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if ((state == DONE) && bus.out_ready) begin
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aluv_exec_unit.sv
// Directed self-checking bench for aluv_exec_unit at default parameters.
module tb_aluv_exec_unit;
  import aluv_pkg::*;

  typedef logic [7:0][7:0] vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  aluv_if #(.DATA_WIDTH(8), .LANES(8), .SELECTOR_SIZE(4)) bus ();

  aluv_exec_unit #(
    .DATA_WIDTH      (8),
    .LANES           (8),
    .SELECTOR_SIZE   (4),
    .LANES_PER_CYCLE (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v8(input int e0, input int e1, input int e2, input int e3,
                              input int e4, input int e5, input int e6, input int e7);
    vec_t r;
    r[0] = e0[7:0]; r[1] = e1[7:0]; r[2] = e2[7:0]; r[3] = e3[7:0];
    r[4] = e4[7:0]; r[5] = e5[7:0]; r[6] = e6[7:0]; r[7] = e7[7:0];
    return r;
  endfunction

  // Drive a request at posedge+1 and return just after the accept edge.
  task automatic send(input logic [3:0] sel, input vec_t a, input vec_t b);
    bus.in_valid = 1'b1;
    bus.selector = sel;
    bus.operand1 = a;
    bus.operand2 = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.selector = 4'b1111;
    bus.operand1 = v8(99, 98, 97, 96, 95, 94, 93, 92);
    bus.operand2 = v8(7, 7, 7, 7, 7, 7, 7, 7);
  endtask

  // Count edges after the accept edge until out_valid rises (bounded).
  task automatic wait_result(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus.out_valid) break;
    end
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b1;
    bus.selector  = ALUV_ADD;
    bus.operand1  = v8(1, 1, 1, 1, 1, 1, 1, 1);
    bus.operand2  = v8(1, 1, 1, 1, 1, 1, 1, 1);
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", bus.out); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_no_accept got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_op(input string name, input logic [3:0] sel, input vec_t a, input vec_t b,
                         input vec_t exp_out, input logic exp_err);
    int n;
    send(sel, a, b);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL %s_busy got=%b exp=0", name, bus.in_ready); end
    wait_result(n);
    total++; if (n !== 4) begin bad++; $display("FAIL %s_latency got=%0d exp=4", name, n); end
    total++; if (bus.out !== exp_out) begin bad++; $display("FAIL %s_out got=%h exp=%h", name, bus.out, exp_out); end
    total++; if (bus.err !== exp_err) begin bad++; $display("FAIL %s_err got=%b exp=%b", name, bus.err, exp_err); end
    retire();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL %s_retire got=%b exp=0", name, bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL %s_idle got=%b exp=1", name, bus.in_ready); end
  endtask

  task automatic test_add();
    test_op("add", ALUV_ADD, v8(1, 4, 2, 5, 255, 5, 0, 5), v8(1, 5, 4, 6, 15, 8, 8, 2),
            v8(2, 9, 6, 11, 14, 13, 8, 7), 1'b0);
  endtask

  task automatic test_sub();
    test_op("sub", ALUV_SUB, v8(1, 14, 31, 4, 255, 5, 5, 5), v8(1, 2, 14, 6, 15, 8, 8, 8),
            v8(0, 12, 17, 254, 240, 253, 253, 253), 1'b0);
  endtask

  task automatic test_mul();
    test_op("mul", ALUV_MUL, v8(1, 14, 1, 4, 0, 2, 2, 5), v8(1, 2, 14, 0, 15, 2, 3, 1),
            v8(1, 28, 14, 0, 0, 4, 6, 5), 1'b0);
    test_op("mul_ovf", ALUV_MUL, v8(16, 255, 3, 0, 0, 0, 0, 0), v8(17, 255, 100, 0, 0, 0, 0, 0),
            v8(16, 1, 44, 0, 0, 0, 0, 0), 1'b0);
  endtask

  task automatic test_unsupported();
    test_op("unsup", 4'b0000, v8(3, 4, 5, 6, 7, 8, 9, 10), v8(1, 2, 3, 4, 5, 6, 7, 8),
            v8(0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
  endtask

  task automatic test_back_to_back();
    int   n;
    vec_t exp_add;
    vec_t exp_sub;
    exp_add = v8(2, 9, 6, 11, 14, 13, 8, 7);
    exp_sub = v8(0, 12, 17, 254, 240, 253, 253, 253);
    send(ALUV_ADD, v8(1, 4, 2, 5, 255, 5, 0, 5), v8(1, 5, 4, 6, 15, 8, 8, 2));
    wait_result(n);
    total++; if (n !== 4) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=4", n); end
    for (int i = 0; i < 10; i++) begin
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, bus.out_valid); end
      total++; if (bus.out !== exp_add) begin bad++; $display("FAIL bp_out cyc=%0d got=%h exp=%h", i, bus.out, exp_add); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.selector  = ALUV_SUB;
    bus.operand1  = v8(1, 14, 31, 4, 255, 5, 5, 5);
    bus.operand2  = v8(1, 2, 14, 6, 15, 8, 8, 8);
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.selector  = 4'b0000;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_fall got=%b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", bus.in_ready); end
    wait_result(n);
    total++; if (n !== 4) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=4", n); end
    total++; if (bus.out !== exp_sub) begin bad++; $display("FAIL b2b_second_out got=%h exp=%h", bus.out, exp_sub); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL b2b_second_err got=%b exp=0", bus.err); end
    retire();
  endtask

  task automatic test_reset_mid();
    logic saw_valid;
    send(ALUV_ADD, v8(9, 9, 9, 9, 9, 9, 9, 9), v8(1, 1, 1, 1, 1, 1, 1, 1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out !== '0) begin bad++; $display("FAIL mid_reset_out got=%h exp=0", bus.out); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_in_ready got=%b exp=1", bus.in_ready); end
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_stale got=%b exp=0", saw_valid); end
    test_op("post_reset", ALUV_ADD, v8(10, 20, 30, 40, 50, 60, 70, 80), v8(1, 2, 3, 4, 5, 6, 7, 200),
            v8(11, 22, 33, 44, 55, 66, 77, 24), 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.selector  = '0;
    bus.operand1  = '0;
    bus.operand2  = '0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_unsupported();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aluv_exec_unit.md
Name: aluv_exec_unit

Overview:
- Sequential vector-ALU execution unit: the responder side of the ALU operand/selector interface.
- Accepts one request (selector, two LANES x DATA_WIDTH operand vectors) over a valid/ready handshake.
- Computes lane-wise ADD/SUB/MUL, LANES_PER_CYCLE lanes per cycle, and holds the result vector until the consumer accepts it.
- Sits between the vector issue stage and the vector register-file writeback.

Parameters:
DATA_WIDTH, 8, bits per lane
LANES, 8, lanes per vector
SELECTOR_SIZE, 4, opcode selector width
LANES_PER_CYCLE, 2, lanes computed per EXEC cycle; LANES must be divisible by it (elaboration-time assertion)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
selector  input  SELECTOR_SIZE  opcode
operand1  input  [LANES][DATA_WIDTH]  source vector A
operand2  input  [LANES][DATA_WIDTH]  source vector B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out  output  [LANES][DATA_WIDTH]  result vector
err  output  1  unsupported selector; valid only while out_valid=1

Behaviour:
- Clocking/reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge.
- Reset values: state=IDLE, out_valid=0, out=0, err=0, lane counter=0, operand/selector registers=0. in_ready=1 after reset.
- Opcodes:
  - 4'b0100 ADD: A+B mod 2^DATA_WIDTH.
  - 4'b1101 SUB: A-B mod 2^DATA_WIDTH (two's complement wrap).
  - 4'b0101 MUL: low DATA_WIDTH bits of A*B (unsigned).
  - Any other selector: every lane result=0, err=1.
- State machine:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch selector/operand1/operand2, clear out, set counter=0, go to EXEC.
  - EXEC: in_ready=0. Each cycle, compute lanes [counter*LPC +: LPC] from the latched operands into the out register and increment counter. After the final group (counter=LANES/LPC-1), set out_valid=1, set err per opcode, and go to DONE.
  - DONE: out and err stable, out_valid=1. On out_ready, clear out_valid and go to IDLE.
- Latency: request accepted at edge t0 -> out_valid=1 after edge t0+LANES/LPC (t0+4 at defaults).
- Simultaneous accept: in DONE, in_ready = out_ready. If out_valid&&out_ready&&in_valid in the same cycle, the result retires and the new request is latched on that edge; state goes directly to EXEC and out_valid falls. This gives back-to-back throughput of one request per LANES/LPC+1 cycles.
- Inputs are ignored outside the accept edge. Changes to operand1/operand2/selector during EXEC/DONE have no effect.
- out_valid never drops without out_ready. out is not modified while out_valid=1.
- Reset mid-operation (EXEC or DONE): the in-flight request is discarded and all outputs return to reset values on that edge. No result is produced.
- in_valid during reset is ignored.
- LANES_PER_CYCLE=LANES: a single EXEC cycle, latency 1.

Decomposition:
- Package aluv_pkg:
  - selector constants ALUV_ADD=4'b0100, ALUV_SUB=4'b1101, ALUV_MUL=4'b0101.
  - state enum {IDLE, EXEC, DONE}.
  - helper function is_supported(selector).
- Sub-module aluv_lane: combinational single-lane ADD/SUB/MUL plus unsupported flag, parameterised by DATA_WIDTH and SELECTOR_SIZE. Instantiated LANES_PER_CYCLE times, fed by a group mux indexed by the counter.

Test Plan:
- ADD: A={1,4,2,5,255,5,0,5}, B={1,5,4,6,15,8,8,2} -> out={2,9,6,11,14,13,8,7}, err=0, out_valid exactly 4 cycles after accept.
- SUB: A={1,14,31,4,255,5,5,5}, B={1,2,14,6,15,8,8,8} -> out={0,12,17,254,240,253,253,253}, err=0.
- MUL: A={1,14,1,4,0,2,2,5}, B={1,2,14,0,15,2,3,1} -> out={1,28,14,0,0,4,6,5}. Overflow lane 16*17 -> 16.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 10 cycles: out_valid and out stay stable, in_ready=0.
  - Then raise out_ready with in_valid=1 carrying the next request: new request accepted on the same edge, and its result appears 4 cycles later.
- Unsupported selector 4'b0000 with any operands -> out=all zeros, err=1, normal handshake.
- Reset mid-operation: deassert rst_n during the 2nd EXEC cycle -> next edge out_valid=0, out=0, in_ready=1, and no stale result ever appears.
